audio_sample_fifo: RTL and testbench
====================================

AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

Interface
REQ-001 Parameter DEPTH, default 8, meaning the number of stereo sample pairs stored; SHALL be a power of 2 and at least 2.
REQ-002 Parameter SAMPLE_W, default 24, meaning the width of each channel sample.
REQ-003 clk  input  1  clock; all state changes SHALL occur on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream (filter output) has a stereo pair this cycle.
REQ-006 in_left  input  SAMPLE_W  left-channel sample, two's complement.
REQ-007 in_right  input  SAMPLE_W  right-channel sample, two's complement.
REQ-008 in_ready  output  1  FIFO can accept a pair; SHALL equal !full.
REQ-009 out_valid  output  1  head pair available; SHALL equal !empty.
REQ-010 out_ready  input  1  downstream (codec write_ready) consumes the head pair.
REQ-011 out_left  output  SAMPLE_W  head left sample.
REQ-012 out_right  output  SAMPLE_W  head right sample.
REQ-013 count  output  clog2(DEPTH)+1  number of pairs stored, 0..DEPTH.
REQ-014 full  output  1  count == DEPTH.
REQ-015 empty  output  1  count == 0.
REQ-016 overflow  output  1  sticky flag: an in_valid pair was dropped.
REQ-017 clr_ovf  input  1  clears overflow.

Function
REQ-018 Push SHALL occur when in_valid && !full; the pair is written at wr_ptr, and wr_ptr advances by 1.
REQ-019 Pop SHALL occur when out_ready && !empty; rd_ptr advances by 1.
REQ-020 Both pointers SHALL wrap from DEPTH-1 to 0.
REQ-021 The FIFO SHALL be first-word-fall-through: out_left/out_right SHALL show the pair at rd_ptr combinationally whenever out_valid=1.
REQ-022 When out_valid=0, out_left/out_right SHALL be 0.
REQ-023 Latency: a pair pushed into an empty FIFO SHALL appear on the outputs with out_valid=1 in the cycle after the push edge.
REQ-024 count next value: +1 on push only, -1 on pop only, unchanged on push and pop together or on neither.
REQ-025 Simultaneous push and pop with 0<count<DEPTH: both SHALL occur; count unchanged.
REQ-026 Full with in_valid and out_ready: the pop SHALL occur and the push SHALL be rejected, because full is evaluated on the current count; the pair is dropped and overflow is set.
REQ-027 Empty with out_ready=1: no pop; pointers and count unchanged; no error flag.
REQ-028 overflow SHALL be set on the edge after any cycle with in_valid && full, and held until clr_ovf or rst.
REQ-029 If clr_ovf coincides with a new drop, set SHALL win.
REQ-030 Sample data SHALL be stored and returned bit-exact; no arithmetic is performed on samples.

Reset
REQ-031 On rst, wr_ptr, rd_ptr, count and overflow SHALL be 0 on the next edge, giving empty=1, full=0, in_ready=1, out_valid=0, and out_left=out_right=0.
REQ-032 rst SHALL override push, pop and clr_ovf in the same cycle.
REQ-033 rst mid-operation SHALL discard all stored pairs; the storage array need not be cleared.

Structure
REQ-034 Shared package audio_pkg SHALL hold SAMPLE_W and the stereo pair struct type (left and right fields).
REQ-035 Storage SHALL be one sub-module, sample_ram: DEPTH x 2*SAMPLE_W, one synchronous write port and one asynchronous read port.
REQ-036 Pointers SHALL be clog2(DEPTH) bits wide; full/empty SHALL derive from count, not from pointer comparison.

Verification
REQ-037 After rst, push 50,-50 ... 57,-57 (8 pairs) with out_ready=0 -> count=8, full=1, in_ready=0, head = 50/-50.
REQ-038 Full FIFO, in_valid with 99/99, out_ready=0 -> pair dropped, overflow=1 next cycle, count stays 8; clr_ovf -> overflow=0.
REQ-039 Drain 8 pairs with out_ready=1 -> outputs 50..57 in order, then empty=1 and out_left=0.
REQ-040 Continuous push and pop for 20 cycles with alternating 60/40 data -> count constant at 1, output equals input delayed one cycle, pointers wrap correctly.
REQ-041 Push 3 pairs, assert rst together with in_valid -> count=0, out_valid=0 next cycle; the next pushed pair appears first.
REQ-042 Empty FIFO, push 0x7FFFFF/0x800000 -> out_valid=1 one cycle later with exact values.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio sample types: default channel width and the stereo pair payload.
package audio_pkg;

    localparam int unsigned SAMPLE_W    = 24;
    localparam int unsigned PAIR_FIELDS = 2;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } stereo_t;

endpackage

// File: rtl/sample_ram.sv
// Pair storage: synchronous write port, asynchronous read port.
module sample_ram #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 48
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write the incoming pair on the clock edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Head read is combinational so the FIFO can fall through.
    assign rdata = mem[raddr];

endmodule

// File: rtl/audio_sample_fifo.sv
// First-word-fall-through FIFO of stereo sample pairs between filter and codec.
module audio_sample_fifo #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned SAMPLE_W = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [SAMPLE_W-1:0]        in_left,
    input  logic [SAMPLE_W-1:0]        in_right,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SAMPLE_W-1:0]        out_left,
    output logic [SAMPLE_W-1:0]        out_right,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    input  logic                       clr_ovf
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned CW     = AW + 1;
    localparam int unsigned DATA_W = audio_pkg::PAIR_FIELDS * SAMPLE_W;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] head;
    logic              push;
    logic              pop;
    logic              drop;

    // Flags decode straight from the stored count.
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == CW'(0));
    assign in_ready  = !full;
    assign out_valid = !empty;

    assign push = in_valid && !full;
    assign pop  = out_ready && !empty;
    assign drop = in_valid && full;

    sample_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (push && !rst),
        .waddr (wr_ptr),
        .wdata ({in_left, in_right}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Head pair is shown only while valid; zero otherwise.
    assign out_left  = empty ? '0 : head[DATA_W-1:SAMPLE_W];
    assign out_right = empty ? '0 : head[SAMPLE_W-1:0];

    // Pointer, occupancy and sticky overflow state; reset dominates everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo with hand-computed expectations.
module tb_audio_sample_fifo;
    import audio_pkg::*;

    localparam int unsigned W  = SAMPLE_W;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_left;
    logic [W-1:0]  in_right;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_left;
    logic [W-1:0]  out_right;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          clr_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    audio_sample_fifo #(.DEPTH(8), .SAMPLE_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_left   (in_left),
        .in_right  (in_right),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_left  (out_left),
        .out_right (out_right),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        in_left  = '0;
        in_right = '0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (count !== 4'd0)     begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_checks++; if (empty !== 1'b1)     begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty); end
        n_checks++; if (full !== 1'b0)      begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_checks++; if (out_left !== '0 || out_right !== '0) begin n_fail++; $display("FAIL reset_out_data got %h/%h exp 0/0", out_left, out_right); end
        n_checks++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_left  = W'(50 + i);
            in_right = W'(-(50 + i));
            step();
            n_checks++; if (count !== CW'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1); end
        end
        in_valid = 1'b0;
        n_checks++; if (full !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full got full=%b in_ready=%b exp 1/0", full, in_ready); end
        n_checks++; if (out_left !== W'(50) || out_right !== W'(-50)) begin n_fail++; $display("FAIL fill_head got %h/%h exp %h/%h", out_left, out_right, W'(50), W'(-50)); end
    endtask

    task automatic test_overflow();
        in_valid = 1'b1;
        in_left  = W'(99);
        in_right = W'(99);
        step();
        in_valid = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", overflow); end
        n_checks++; if (count !== 4'd8)    begin n_fail++; $display("FAIL ovf_count got %0d exp 8", count); end
        n_checks++; if (out_left !== W'(50)) begin n_fail++; $display("FAIL ovf_head got %h exp %h", out_left, W'(50)); end
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", overflow); end
        // clear coinciding with a fresh drop: set must win
        in_valid = 1'b1;
        clr_ovf  = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got %b exp 1", overflow); end
        step();
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear2 got %b exp 0", overflow); end
        clr_ovf = 1'b0;
    endtask

    task automatic test_drain();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_left !== W'(50 + i) || out_right !== W'(-(50 + i)))
                begin n_fail++; $display("FAIL drain[%0d] got v=%b %h/%h exp 1 %h/%h", i, out_valid, out_left, out_right, W'(50 + i), W'(-(50 + i))); end
            step();
        end
        n_checks++; if (empty !== 1'b1 || out_left !== '0 || out_right !== '0) begin n_fail++; $display("FAIL drain_empty got empty=%b %h/%h exp 1 0/0", empty, out_left, out_right); end
        // pop request on empty does nothing and flags nothing
        step();
        out_ready = 1'b0;
        n_checks++; if (count !== 4'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL empty_pop got count=%0d ovf=%b exp 0/0", count, overflow); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] l_exp;
        logic [W-1:0] r_exp;
        in_valid = 1'b1;
        in_left  = W'(60);
        in_right = W'(40);
        step();
        out_ready = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            l_exp    = W'(((k - 1) % 2 == 1 ? 40 : 60) + (k - 1));
            r_exp    = W'(((k - 1) % 2 == 1 ? 60 : 40) + (k - 1));
            in_left  = W'((k % 2 == 1 ? 40 : 60) + k);
            in_right = W'((k % 2 == 1 ? 60 : 40) + k);
            n_checks++; if (count !== 4'd1 || out_left !== l_exp || out_right !== r_exp)
                begin n_fail++; $display("FAIL stream[%0d] got cnt=%0d %h/%h exp 1 %h/%h", k, count, out_left, out_right, l_exp, r_exp); end
            step();
        end
        in_valid = 1'b0;
        n_checks++; if (out_left !== W'(80) || out_right !== W'(60)) begin n_fail++; $display("FAIL stream_last got %h/%h exp %h/%h", out_left, out_right, W'(80), W'(60)); end
        step();
        out_ready = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL stream_empty got %b exp 1", empty); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_left  = W'(10 + i);
            in_right = W'(20 + i);
            step();
        end
        in_left   = W'(99);
        in_right  = W'(99);
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++; if (count !== 4'd7 || overflow !== 1'b1) begin n_fail++; $display("FAIL full_pp got cnt=%0d ovf=%b exp 7/1", count, overflow); end
        n_checks++; if (out_left !== W'(11)) begin n_fail++; $display("FAIL full_pp_head got %h exp %h", out_left, W'(11)); end
        clr_ovf = 1'b1;
        step();
        clr_ovf   = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            n_checks++; if (out_left !== W'(10 + i) || out_right !== W'(20 + i))
                begin n_fail++; $display("FAIL full_pp_drain[%0d] got %h/%h exp %h/%h", i, out_left, out_right, W'(10 + i), W'(20 + i)); end
            step();
        end
        out_ready = 1'b0;
        n_checks++; if (empty !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL full_pp_end got empty=%b ovf=%b exp 1/0", empty, overflow); end
    endtask

    task automatic test_rst_mid();
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_left  = W'(i);
            in_right = W'(i);
            step();
        end
        in_left   = W'(77);
        in_right  = W'(77);
        out_ready = 1'b1;
        rst       = 1'b1;
        step();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid got cnt=%0d v=%b exp 0/0", count, out_valid); end
        in_valid = 1'b1;
        in_left  = W'(5);
        in_right = W'(-5);
        step();
        in_valid = 1'b0;
        n_checks++; if (count !== 4'd1 || out_left !== W'(5) || out_right !== W'(-5))
            begin n_fail++; $display("FAIL rst_mid_first got cnt=%0d %h/%h exp 1 %h/%h", count, out_left, out_right, W'(5), W'(-5)); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_extremes();
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ext_pre_empty got %b exp 1", empty); end
        in_valid = 1'b1;
        in_left  = 24'h7FFFFF;
        in_right = 24'h800000;
        step();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_left !== 24'h7FFFFF || out_right !== 24'h800000)
            begin n_fail++; $display("FAIL ext_data got v=%b %h/%h exp 1 7fffff/800000", out_valid, out_left, out_right); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ext_empty got %b exp 1", empty); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_back_to_back();
        test_full_push_pop();
        test_rst_mid();
        test_extremes();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
